// File: rtl/aix_mul_pkg.sv
// Shared definitions for the dual-INT8 multiply/accumulate path.
//   MUL_LAT_DEF : default cycles from mul input to valid ac/bc
//   ACC_W_DEF   : default signed accumulator width
//   INT8_W      : operand width
//   PROD16_W    : width of each signed product returned by mul
//   acc_pair_t  : one completed group result {acc_a, acc_b}
package aix_mul_pkg;

  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned INT8_W      = 8;
  localparam int unsigned PROD16_W    = 16;

  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] acc_a;
    logic signed [ACC_W_DEF-1:0] acc_b;
  } acc_pair_t;

endpackage

// File: rtl/mul_pair_mac_seq_if.sv
// Beat-in / result-out bus of mul_pair_mac_seq.
//   in_valid/in_ready/in_a/in_b/in_c/in_last : input beat stream
//   clr                                      : synchronous abort
//   out_valid/out_ready/out_acc_a/out_acc_b  : result stream
//   busy                                     : work in flight or buffered
// master = producer/consumer side, slave = the sequencer.
interface mul_pair_mac_seq_if #(
  parameter int unsigned ACC_W = aix_mul_pkg::ACC_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_a;
  logic signed [7:0] in_b;
  logic signed [7:0] in_c;
  logic              in_last;
  logic              clr;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc_a;
  logic signed [ACC_W-1:0] out_acc_b;
  logic                    busy;

  modport master (
    output in_valid, in_a, in_b, in_c, in_last, clr, out_ready,
    input  in_ready, out_valid, out_acc_a, out_acc_b, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_last, clr, out_ready,
    output in_ready, out_valid, out_acc_a, out_acc_b, busy
  );

endinterface

// File: rtl/acc_out_fifo2.sv
// Two-entry result FIFO. Entry 0 is always the head; a pop shifts entry 1 down.
// Push and pop in the same cycle are allowed and leave the count unchanged.
// The caller guarantees no push into a full FIFO without a matching pop.
//   clk, rstn  : clock, asynchronous active-low reset
//   flush      : synchronous empty
//   push       : write push_data
//   pop        : consume head (ignored when empty)
//   head       : head entry
//   valid      : head entry valid
//   count      : number of stored entries (0..2)
module acc_out_fifo2 #(
  parameter int unsigned WIDTH = 48
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       count_s;
  logic             pop_eff;

  always_comb begin
    pop_eff = pop && (count_q != 2'd0);
    mem0_d  = pop_eff ? mem1_q : mem0_q;
    mem1_d  = mem1_q;
    count_s = count_q - {1'b0, pop_eff};
    // Push lands in the first free slot after the pop has been applied.
    if (push) begin
      if (count_s == 2'd0) begin
        mem0_d = push_data;
      end else begin
        mem1_d = push_data;
      end
    end
    count_d = count_s + {1'b0, push};
    if (flush) begin
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/mul.sv
// Dual signed INT8 multiplier sharing one weight: ac = a*c, bc = b*c.
// Fixed LAT-stage pipeline with no clock enable and no reset, like the DSP it
// stands in for; downstream logic qualifies the outputs with its own valids.
//   clk        : clock
//   a, b, c    : signed INT8 operands
//   ac, bc     : signed 16-bit products, LAT cycles after the operands
module mul #(
  parameter int unsigned LAT = 3
) (
  input  logic               clk,
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  input  logic signed [7:0]  c,
  output logic signed [15:0] ac,
  output logic signed [15:0] bc
);

  logic signed [15:0] ac_q [LAT];
  logic signed [15:0] bc_q [LAT];

  always_ff @(posedge clk) begin
    ac_q[0] <= 16'(a) * 16'(c);
    bc_q[0] <= 16'(b) * 16'(c);
    for (int i = 1; i < LAT; i++) begin
      ac_q[i] <= ac_q[i-1];
      bc_q[i] <= bc_q[i-1];
    end
  end

  assign ac = ac_q[LAT-1];
  assign bc = bc_q[LAT-1];

endmodule

// File: rtl/mul_pair_mac_seq.sv
// Sequencer/accumulator around the dual-INT8 multiplier. Accepted beats are
// registered and issued to mul one per cycle; a valid/last shift register
// tracks them through the fixed mul latency. At the pipe tail both products
// are sign-extended and accumulated per group; a last beat pushes the group
// sums into a 2-entry output FIFO.
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   bus   : beat/result stream, clr and busy (slave side)
module mul_pair_mac_seq #(
  parameter int unsigned MUL_LAT = aix_mul_pkg::MUL_LAT_DEF,
  parameter int unsigned ACC_W   = aix_mul_pkg::ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  mul_pair_mac_seq_if.slave bus
);

  import aix_mul_pkg::*;

  logic                      rdy_en_q;
  logic                      in_ready;
  logic                      accept;

  logic signed [INT8_W-1:0]  a_q, b_q, c_q;
  logic                      iss_vld_q, iss_last_q;
  logic [MUL_LAT-1:0]        vld_q, last_q;
  logic                      tail_vld, tail_last;

  logic signed [PROD16_W-1:0] p_a, p_b;
  logic signed [ACC_W-1:0]    acc_a_q, acc_b_q;
  logic signed [ACC_W-1:0]    sum_a, sum_b;
  logic                       first_q;

  logic [1:0]                last_inflight_q, last_inflight_d;
  logic [1:0]                buf_count;
  logic [2:0]                credit_used;
  logic                      buf_push, buf_valid;
  logic [2*ACC_W-1:0]        buf_head;

  // Credits: every last beat in flight reserves one FIFO slot, so a result
  // always has room when it reaches the tail and the pipe never stalls.
  assign credit_used = {1'b0, buf_count} + {1'b0, last_inflight_q};
  assign in_ready    = rdy_en_q && !bus.clr && (credit_used < 3'd2);
  assign accept      = bus.in_valid && in_ready;

  // Holds in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      iss_vld_q  <= 1'b0;
      iss_last_q <= 1'b0;
    end else begin
      iss_vld_q  <= accept;
      iss_last_q <= accept && bus.in_last;
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
        c_q <= bus.in_c;
      end
    end
  end

  mul #(
    .LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .ac  (p_a),
    .bc  (p_b)
  );

  // Valid/last travel alongside mul; clr squashes everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (bus.clr) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= {vld_q[MUL_LAT-2:0], iss_vld_q};
      last_q <= {last_q[MUL_LAT-2:0], iss_last_q};
    end
  end

  assign tail_vld  = vld_q[MUL_LAT-1] && !bus.clr;
  assign tail_last = tail_vld && last_q[MUL_LAT-1];

  always_comb begin
    sum_a = {{(ACC_W-PROD16_W){p_a[PROD16_W-1]}}, p_a};
    sum_b = {{(ACC_W-PROD16_W){p_b[PROD16_W-1]}}, p_b};
    if (!first_q) begin
      sum_a = acc_a_q + sum_a;
      sum_b = acc_b_q + sum_b;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      first_q <= 1'b1;
    end else if (bus.clr) begin
      first_q <= 1'b1;
    end else if (tail_vld) begin
      acc_a_q <= sum_a;
      acc_b_q <= sum_b;
      first_q <= tail_last;
    end
  end

  always_comb begin
    last_inflight_d = last_inflight_q;
    if (bus.clr) begin
      last_inflight_d = 2'd0;
    end else begin
      if (accept && bus.in_last) begin
        last_inflight_d = last_inflight_d + 2'd1;
      end
      if (tail_last) begin
        last_inflight_d = last_inflight_d - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_inflight_q <= 2'd0;
    end else begin
      last_inflight_q <= last_inflight_d;
    end
  end

  assign buf_push = tail_last;

  acc_out_fifo2 #(
    .WIDTH (2 * ACC_W)
  ) u_acc_out_fifo2 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.clr),
    .push      (buf_push),
    .push_data ({sum_a, sum_b}),
    .pop       (bus.out_ready),
    .head      (buf_head),
    .valid     (buf_valid),
    .count     (buf_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = buf_valid;
  assign bus.out_acc_a = buf_head[2*ACC_W-1:ACC_W];
  assign bus.out_acc_b = buf_head[ACC_W-1:0];
  assign bus.busy      = iss_vld_q || (|vld_q) || !first_q || (buf_count != 2'd0);

endmodule

// File: tb/tb_mul_pair_mac_seq.sv
module tb_mul_pair_mac_seq;
  import aix_mul_pkg::*;

  localparam int unsigned LAT = MUL_LAT_DEF;
  localparam int unsigned AW  = ACC_W_DEF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mul_pair_mac_seq_if #(.ACC_W(AW)) bus ();

  mul_pair_mac_seq #(
    .MUL_LAT (LAT),
    .ACC_W   (AW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_acc   = 0;
  int n_pop   = 0;
  bit rnd_ready = 1'b0;

  // Reference model: running group sums and the queue of finished groups.
  longint    part_a = 0;
  longint    part_b = 0;
  acc_pair_t exp_q[$];
  acc_pair_t mon_e;
  logic signed [AW-1:0] last_a, last_b;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      part_a = 0;
      part_b = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        last_a = bus.out_acc_a;
        last_b = bus.out_acc_b;
        check("out_pending", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_acc_a", bus.out_acc_a, mon_e.acc_a);
          check("out_acc_b", bus.out_acc_b, mon_e.acc_b);
        end
      end
      if (bus.clr) begin
        exp_q.delete();
        part_a = 0;
        part_b = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        n_acc++;
        part_a += longint'(bus.in_a) * longint'(bus.in_c);
        part_b += longint'(bus.in_b) * longint'(bus.in_c);
        if (bus.in_last) begin
          mon_e.acc_a = AW'(part_a);
          mon_e.acc_b = AW'(part_b);
          exp_q.push_back(mon_e);
          part_a = 0;
          part_b = 0;
        end
      end
    end
  end

  task automatic rnd_out_ready();
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int a, input int b, input int c, input bit last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'(a);
    bus.in_b     = 8'(b);
    bus.in_c     = 8'(c);
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      rnd_out_ready();
      @(negedge clk);
      n++;
    end
    check("send_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rnd_out_ready();
  endtask

  task automatic wait_pop(input int target);
    int n = 0;
    while (n_pop < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("pop_wait", n_pop, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, pop0, acc0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.in_last   = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_acc_a", bus.out_acc_a, 0);
    check("rst_out_acc_b", bus.out_acc_b, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready_first_cycle", bus.in_ready, 0);
    @(negedge clk);
    check("rst_ready_after", bus.in_ready, 1);
    @(posedge clk); #1;

    // Group of 3 with latency check
    bus.out_ready = 1'b1;
    send(3, -2, 5, 1'b0);
    send(1, 1, -4, 1'b0);
    send(-7, 0, 2, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 50);
    check("t1_latency", k, LAT + 2);
    @(posedge clk); #1;
    check("t1_acc_a", last_a, -3);
    check("t1_acc_b", last_b, -14);

    // Extremes
    pop0 = n_pop;
    for (int i = 0; i < 4; i++) send(-128, -128, -128, i == 3);
    wait_pop(pop0 + 1);
    check("t2_acc_a", last_a, 65536);
    check("t2_acc_b", last_b, 65536);
    send(127, -128, 127, 1'b1);
    wait_pop(pop0 + 2);
    check("t2b_acc_a", last_a, 16129);
    check("t2b_acc_b", last_b, -16256);

    // Backpressure: only two single-beat groups fit
    wait_idle();
    bus.out_ready = 1'b0;
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'(i + 10);
      bus.in_b     = 8'(-i);
      bus.in_c     = 8'(3);
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("t3_accepts", n_acc - acc0, 2);
    check("t3_ready_low", bus.in_ready, 0);
    check("t3_out_valid", bus.out_valid, 1);
    check("t3_no_pop", n_pop - pop0, 0);
    bus.out_ready = 1'b1;
    wait_pop(pop0 + 2);
    wait_idle();
    check("t3_ready_back", bus.in_ready, 1);

    // Streaming single-beat groups with out_ready held high
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      bus.in_c     = 8'($urandom);
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_idle();
    check("t4_no_loss", n_pop - pop0, n_acc - acc0);

    // clr mid-group
    send(5, 6, 7, 1'b0);
    send(1, 2, 3, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a     = 8'(9);
    bus.in_b     = 8'(9);
    bus.in_c     = 8'(9);
    bus.in_last  = 1'b1;
    bus.clr      = 1'b1;
    @(negedge clk);
    check("t5_clr_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    pop0 = n_pop;
    send(2, 3, 4, 1'b1);
    wait_pop(pop0 + 1);
    check("t5_acc_a", last_a, 8);
    check("t5_acc_b", last_b, 12);
    repeat (10) @(posedge clk);
    #1;
    check("t5_single", n_pop - pop0, 1);

    // Reset mid-group with a result buffered
    wait_idle();
    bus.out_ready = 1'b0;
    pop0 = n_pop;
    send(1, 2, 3, 1'b1);
    send(4, 5, 6, 1'b0);
    send(7, 8, 9, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("t6_buffered", bus.out_valid, 1);
    rstn = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_in_ready", bus.in_ready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    send(1, 1, 1, 1'b1);
    wait_pop(pop0 + 1);
    check("t6_acc_a", last_a, 1);
    check("t6_acc_b", last_b, 1);

    // Randomized groups with random output backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rnd_out_ready();
      end
      send(int'($urandom), int'($urandom), int'($urandom),
           ($urandom_range(0, 3) == 0) || (i == 149));
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_out_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
